camera_pixel_assembler: RTL and testbench

//   Upstream stage of the feature-based face detector.

---
 rtl/cam_pkg.sv | 34 +++
 rtl/camera_pixel_assembler_if.sv | 23 ++
 rtl/colour_bar_gen.sv | 20 ++
 rtl/camera_pixel_assembler.sv | 191 +++++++++++++++++++
 tb/tb_camera_pixel_assembler.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared state encoding, RGB565 colour constants and frame-size helper
// for the camera pixel assembler.
package cam_pkg;

  typedef enum logic [2:0] {
    WAIT_VS,
    WAIT_HREF,
    BYTE1,
    BYTE0,
    LINE_END,
    PAD_LINE,
    PAD_FRAME
  } cam_state_e;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // Element 0 is the leftmost bar (white).
  localparam logic [7:0][15:0] BAR_COLOURS = {
    RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
    RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE
  };

  function automatic logic [18:0] frame_pixels(input int w, input int h);
    return 19'(w * h);
  endfunction

endpackage

// File: rtl/camera_pixel_assembler_if.sv
// Camera byte bus in, assembled pixel stream out.
// slave: the assembler; master: the camera source / pixel sink side.
interface camera_pixel_assembler_if;
  logic [7:0]  cam_data;
  logic        cam_href;
  logic        cam_vsync;
  logic        cam_byte_en;
  logic [15:0] pixel_out;
  logic        data_valid_out;
  logic        sof;
  logic        eol;
  logic        frame_err;

  modport master (
    output cam_data, cam_href, cam_vsync, cam_byte_en,
    input  pixel_out, data_valid_out, sof, eol, frame_err
  );

  modport slave (
    input  cam_data, cam_href, cam_vsync, cam_byte_en,
    output pixel_out, data_valid_out, sof, eol, frame_err
  );
endinterface

// File: rtl/colour_bar_gen.sv
// Maps a pixel column to one of eight equal-width vertical RGB565 colour bars.
module colour_bar_gen
  import cam_pkg::*;
#(
  parameter int IMG_WIDTH = 640
) (
  input  logic [9:0]  x,
  output logic [15:0] colour
);

  localparam int BAR_W = (IMG_WIDTH / 8 > 0) ? IMG_WIDTH / 8 : 1;

  logic [9:0] bar_idx;

  always_comb begin
    bar_idx = x / 10'(BAR_W);
    colour  = (bar_idx > 10'd7) ? BAR_COLOURS[7] : BAR_COLOURS[bar_idx[2:0]];
  end

endmodule

// File: rtl/camera_pixel_assembler.sv
// Assembles RGB565 pixels from the 8-bit camera bus and pads short lines/frames
// so every frame carries exactly IMG_WIDTH*IMG_HEIGHT pixels. CAM_TEST_PATTERN_EN adds colour bars.
module camera_pixel_assembler
  import cam_pkg::*;
#(
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int HI_BYTE_FIRST = 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CAM_TEST_PATTERN_EN
  input  logic tp_enable,
`endif
  camera_pixel_assembler_if.slave bus
);

  localparam logic [9:0]  W_LIM     = 10'(IMG_WIDTH);
  localparam logic [9:0]  H_LIM     = 10'(IMG_HEIGHT);
  localparam logic [18:0] FRAME_PIX = frame_pixels(IMG_WIDTH, IMG_HEIGHT);

  cam_state_e  state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [18:0] cnt_q, cnt_d;
  logic [7:0]  byte0_q, byte0_d;
  logic        vsync_q, vsync_d;
  logic        err_q, err_d;
  logic [15:0] pixel_q, pixel_d;
  logic        valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;

  logic        vs_fall, vs_rise, byte_ok, emit, emit_cam;
  logic [15:0] cam_word, cam_pix;

  assign vsync_d  = bus.cam_vsync;
  assign vs_fall  = vsync_q & ~bus.cam_vsync;
  assign vs_rise  = ~vsync_q & bus.cam_vsync;
  assign byte_ok  = bus.cam_href & bus.cam_byte_en;
  assign cam_word = (HI_BYTE_FIRST != 0) ? {byte0_q, bus.cam_data} : {bus.cam_data, byte0_q};

`ifdef CAM_TEST_PATTERN_EN
  logic        tp_q, tp_d;
  logic [15:0] bar_colour;

  colour_bar_gen #(.IMG_WIDTH(IMG_WIDTH)) u_bar (
    .x      (x_q),
    .colour (bar_colour)
  );

  assign cam_pix = tp_q ? bar_colour : cam_word;
`else
  assign cam_pix = cam_word;
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    byte0_d  = byte0_q;
    err_d    = err_q;
    emit     = 1'b0;
    emit_cam = 1'b0;
`ifdef CAM_TEST_PATTERN_EN
    tp_d     = tp_q;
`endif
    unique case (state_q)
      WAIT_VS: if (vs_fall) begin
        state_d = WAIT_HREF;
        x_d     = '0;
        y_d     = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
`ifdef CAM_TEST_PATTERN_EN
        tp_d    = tp_enable;
`endif
      end
      WAIT_HREF: if (byte_ok) begin
        byte0_d = bus.cam_data;
        state_d = BYTE1;
      end
      BYTE1: begin
        // href low here means an odd byte count: the half pixel is lost.
        if (!bus.cam_href) begin
          err_d   = 1'b1;
          state_d = LINE_END;
        end else if (bus.cam_byte_en) begin
          state_d = BYTE0;
          if (x_q < W_LIM) begin
            emit     = 1'b1;
            emit_cam = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BYTE0: begin
        if (!bus.cam_href) begin
          state_d = LINE_END;
        end else if (bus.cam_byte_en) begin
          byte0_d = bus.cam_data;
          state_d = BYTE1;
        end
      end
      LINE_END: begin
        if (x_q < W_LIM) begin
          err_d   = 1'b1;
          state_d = PAD_LINE;
        end else begin
          x_d     = '0;
          y_d     = y_q + 10'd1;
          state_d = (y_q + 10'd1 == H_LIM) ? WAIT_VS : WAIT_HREF;
        end
      end
      PAD_LINE: begin
        emit = 1'b1;
        if (x_q == W_LIM - 10'd1) state_d = LINE_END;
      end
      PAD_FRAME: begin
        // x may sit at W when the camera quit right after a full line; wrap it before padding on.
        if (cnt_q >= FRAME_PIX) begin
          state_d = WAIT_VS;
        end else if (x_q >= W_LIM) begin
          x_d = '0;
          y_d = y_q + 10'd1;
        end else begin
          emit = 1'b1;
          if (cnt_q == FRAME_PIX - 19'd1) state_d = WAIT_VS;
        end
      end
      default: state_d = WAIT_VS;
    endcase

    if (emit) begin
      x_d   = x_q + 10'd1;
      cnt_d = cnt_q + 19'd1;
    end

    // Early vsync: abandon the camera and fill the rest of the frame with black.
    if (vs_rise && state_q != WAIT_VS && state_q != PAD_FRAME) begin
      state_d = PAD_FRAME;
      err_d   = 1'b1;
    end

    valid_d = emit;
    sof_d   = emit & (x_q == 10'd0) & (y_q == 10'd0);
    eol_d   = emit & (x_q == W_LIM - 10'd1);
    pixel_d = pixel_q;
    if (emit) pixel_d = emit_cam ? cam_pix : RGB_BLACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_VS;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      byte0_q <= '0;
      vsync_q <= 1'b1;
      err_q   <= 1'b0;
      pixel_q <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
`ifdef CAM_TEST_PATTERN_EN
      tp_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      byte0_q <= byte0_d;
      vsync_q <= vsync_d;
      err_q   <= err_d;
      pixel_q <= pixel_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
`ifdef CAM_TEST_PATTERN_EN
      tp_q    <= tp_d;
`endif
    end
  end

  assign bus.pixel_out      = pixel_q;
  assign bus.data_valid_out = valid_q;
  assign bus.sof            = sof_q;
  assign bus.eol            = eol_q;
  assign bus.frame_err      = err_q;

endmodule

// File: tb/tb_camera_pixel_assembler.sv
// Scoreboard bench: two assemblers (high-byte-first and low-byte-first) share one camera bus;
// a reduced frame size keeps runs short.
module tb_camera_pixel_assembler;

  localparam int W = 16;
  localparam int H = 4;

  typedef struct {
    logic [15:0] p1;
    logic [15:0] p2;
    logic        sof;
    logic        eol;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tp_en = 1'b0;
  always #5 clk = ~clk;

  camera_pixel_assembler_if bus ();
  camera_pixel_assembler_if bus2 ();

  assign bus2.cam_data    = bus.cam_data;
  assign bus2.cam_href    = bus.cam_href;
  assign bus2.cam_vsync   = bus.cam_vsync;
  assign bus2.cam_byte_en = bus.cam_byte_en;

  camera_pixel_assembler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .HI_BYTE_FIRST(1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CAM_TEST_PATTERN_EN
    .tp_enable (tp_en),
`endif
    .bus       (bus)
  );

  camera_pixel_assembler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .HI_BYTE_FIRST(0)) u_dut_lo (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CAM_TEST_PATTERN_EN
    .tp_enable (tp_en),
`endif
    .bus       (bus2)
  );

  exp_t q[$];
  int n_chk = 0, n_pass = 0, n_vld = 0, cyc = 0;
  int mx = 0, my = 0;
  bit tp_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] bar(input int x);
    case (x / (W / 8))
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] byte_val(input int mode, input int k);
    case (mode)
      0: return (k % 2 == 0) ? 8'hF8 : 8'h00;
      2: return (k % 2 == 0) ? 8'h1F : 8'h00;
      default: return (k % 2 == 0) ? 8'(my * 29 + k * 7 + 3) : 8'(k * 13 ^ 8'hA5);
    endcase
  endfunction

  task automatic push(input logic [15:0] p1, input logic [15:0] p2, input int c);
    exp_t e;
    e.p1  = p1;
    e.p2  = p2;
    e.sof = (mx == 0 && my == 0);
    e.eol = (mx == W - 1);
    e.cyc = c;
    q.push_back(e);
    mx++;
  endtask

  // Bytes on an already-high href; model=0 drives junk the DUT must ignore.
  task automatic send_bytes(input int n, input int mode, input bit model);
    logic [7:0] b, prev;
    prev = 8'h00;
    for (int k = 0; k < n; k++) begin
      b = model ? byte_val(mode, k) : 8'($urandom);
      bus.cam_data    = b;
      bus.cam_byte_en = 1'b1;
      if (model && k % 2 == 1 && mx < W) begin
        if (tp_mode) push(bar(mx), bar(mx), cyc + 1);
        else         push({prev, b}, {b, prev}, cyc + 1);
      end
      prev = b;
      tick();
      bus.cam_byte_en = 1'b0;
      tick();
    end
  endtask

  task automatic send_line(input int nbytes, input int mode);
    bus.cam_href = 1'b1;
    tick();
    send_bytes(nbytes, mode, 1'b1);
    bus.cam_href = 1'b0;
    while (mx < W) push(16'h0000, 16'h0000, -1);
    mx = 0;
    my++;
    repeat (W + 6) tick();
  endtask

  task automatic vs_frame(input int hold);
    bus.cam_vsync = 1'b1;
    repeat (hold) tick();
    bus.cam_vsync = 1'b0;
    mx = 0;
    my = 0;
    repeat (4) tick();
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.data_valid_out) begin
      exp_t e;
      n_vld++;
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'(bus.data_valid_out), 32'd0);
      end else begin
        e = q.pop_front();
        chk("pixel_hi_first", 32'(bus.pixel_out), 32'(e.p1));
        chk("valid_lo_first", 32'(bus2.data_valid_out), 32'd1);
        chk("pixel_lo_first", 32'(bus2.pixel_out), 32'(e.p2));
        chk("sof", 32'(bus.sof), 32'(e.sof));
        chk("eol", 32'(bus.eol), 32'(e.eol));
        if (e.cyc >= 0) chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.cam_data    = 8'h00;
    bus.cam_href    = 1'b0;
    bus.cam_vsync   = 1'b1;
    bus.cam_byte_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_pixel", 32'(bus.pixel_out), 32'd0);
    chk("rst_valid", 32'(bus.data_valid_out), 32'd0);
    chk("rst_sof", 32'(bus.sof), 32'd0);
    chk("rst_eol", 32'(bus.eol), 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Clean frame of F8,00.
    vs_frame(3);
    base = n_vld;
    for (int l = 0; l < H; l++) send_line(2 * W, 0);
    chk("f1_err", 32'(bus.frame_err), 32'd0);
    chk("f1_count", 32'(n_vld - base), 32'(W * H));

    // Short line, then overlong odd line.
    vs_frame(3);
    base = n_vld;
    send_line(2 * W, 1);
    send_line(2 * 12, 1);
    send_line(2 * W + 1, 1);
    send_line(2 * W, 1);
    chk("f2_err", 32'(bus.frame_err), 32'd1);
    chk("f2_count", 32'(n_vld - base), 32'(W * H));

    // Early vsync after two lines; rest of frame padded.
    vs_frame(3);
    chk("f3_err_cleared", 32'(bus.frame_err), 32'd0);
    base = n_vld;
    send_line(2 * W, 1);
    send_line(2 * W, 1);
    while (my < H) begin
      while (mx < W) push(16'h0000, 16'h0000, -1);
      mx = 0;
      my++;
    end
    bus.cam_vsync = 1'b1;
    repeat (W * H + 40) tick();
    chk("f3_err", 32'(bus.frame_err), 32'd1);
    chk("f3_count", 32'(n_vld - base), 32'(W * H));

    // Reset mid-line with a half pixel pending.
    vs_frame(3);
    send_line(2 * 10, 1);
    bus.cam_href = 1'b1;
    tick();
    send_bytes(3, 1, 1'b1);
    chk("pre_rst_err", 32'(bus.frame_err), 32'd1);
    chk("q_at_reset", 32'(q.size()), 32'd0);
    q.delete();
    rst_n = 1'b0;
    bus.cam_vsync = 1'b1;
    #1;
    chk("mid_rst_pixel", 32'(bus.pixel_out), 32'd0);
    chk("mid_rst_valid", 32'(bus.data_valid_out), 32'd0);
    chk("mid_rst_err", 32'(bus.frame_err), 32'd0);
    chk("mid_rst_lo_pixel", 32'(bus2.pixel_out), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    send_bytes(2 * W, 1, 1'b0);
    bus.cam_href = 1'b0;
    repeat (4) tick();

    // Recovery frame of 1F,00.
    vs_frame(3);
    base = n_vld;
    for (int l = 0; l < H; l++) send_line(2 * W, 2);
    chk("f5_err", 32'(bus.frame_err), 32'd0);
    chk("f5_count", 32'(n_vld - base), 32'(W * H));

`ifdef CAM_TEST_PATTERN_EN
    tp_en = 1'b1;
    tp_mode = 1'b1;
    vs_frame(3);
    tp_en = 1'b0;
    base = n_vld;
    for (int l = 0; l < H; l++) send_line(2 * W, 1);
    chk("tp_count", 32'(n_vld - base), 32'(W * H));
    tp_mode = 1'b0;
`endif

    repeat (5) tick();
    chk("q_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
